// File: rtl/fifoc_cmd_frame_rx.sv
// Command-frame receiver: reads HDR0, HDR1, NCMD command bytes and a checksum from the command RX FIFO,
// then commits the command bytes atomically. Define FIFOC_CMD_XOR_CHK_EN for an XOR checksum instead of the mod-256 sum.
module fifoc_cmd_frame_rx #(
    parameter int unsigned NCMD   = 9,
    parameter int unsigned RD_LAT = 2,
    parameter logic [7:0]  HDR0   = 8'h55,
    parameter logic [7:0]  HDR1   = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    output logic              fd,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              fifoc_rxen,
    input  logic [7:0]        fifoc_rxd,
    output logic [8*NCMD-1:0] cmd_bus,
    output logic              cmd_valid,
    output logic [3:0]        check_show
);

    localparam int unsigned FLEN = NCMD + 3;
    localparam int unsigned CW   = 6;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_PRE  = 4'd1,
        S_HED  = 4'd2,
        S_CMD  = 4'd3,
        S_CHK  = 4'd4,
        S_LAST = 4'd5,
        S_ERR  = 4'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             lat_q, lat_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [CW-1:0]          rdcnt_q, rdcnt_d;
    logic                   rxen_q, rxen_d;
    logic [7:0]             csum_q, csum_d;
    logic [NCMD-1:0][7:0]   shadow_q, shadow_d;
    logic [8*NCMD-1:0]      cmd_bus_q, cmd_bus_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [7:0]             csum_nx;
    logic                   hdr_ok;
    logic                   last_cmd;
    logic                   csum_match;

`ifdef FIFOC_CMD_XOR_CHK_EN
    assign csum_nx = csum_q ^ fifoc_rxd;
`else
    assign csum_nx = csum_q + fifoc_rxd;
`endif

    // bcnt counts sampled bytes: 0..1 header, 2..NCMD+1 commands, NCMD+2 checksum
    assign hdr_ok     = (bcnt_q == '0) ? (fifoc_rxd == HDR0) : (fifoc_rxd == HDR1);
    assign last_cmd   = (bcnt_q == CW'(NCMD + 1));
    assign csum_match = (fifoc_rxd == csum_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fs) state_d = S_PRE;
            S_PRE:  if (lat_q == 2'(RD_LAT - 1)) state_d = S_HED;
            S_HED: begin
                if (!hdr_ok)              state_d = S_ERR;
                else if (bcnt_q != '0)    state_d = S_CMD;
            end
            S_CMD:  if (last_cmd) state_d = S_CHK;
            S_CHK:  state_d = csum_match ? S_LAST : S_ERR;
            S_LAST: if (!fs) state_d = S_IDLE;
            S_ERR:  if (!fs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fd         = (state_q == S_LAST);
        err        = (state_q == S_ERR);
        check_show = ~4'(state_q);
    end

    always_comb begin
        lat_d       = lat_q;
        bcnt_d      = bcnt_q;
        rdcnt_d     = rdcnt_q;
        rxen_d      = rxen_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        cmd_bus_d   = cmd_bus_q;
        cmd_valid_d = 1'b0;
        err_code_d  = err_code_q;

        // read-enable burst runs independently of sampling; only a header error cuts it short
        if (rxen_q) begin
            if (rdcnt_q == CW'(FLEN)) begin
                rxen_d  = 1'b0;
                rdcnt_d = '0;
            end else begin
                rdcnt_d = rdcnt_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                lat_d      = '0;
                bcnt_d     = '0;
                csum_d     = '0;
                err_code_d = '0;
                if (fs) begin
                    rxen_d  = 1'b1;
                    rdcnt_d = CW'(1);
                end
            end
            S_PRE: lat_d = lat_q + 2'd1;
            S_HED: begin
                bcnt_d = bcnt_q + CW'(1);
                if (!hdr_ok) begin
                    err_code_d = 2'b01;
                    rxen_d     = 1'b0;
                    rdcnt_d    = '0;
                end
            end
            S_CMD: begin
                bcnt_d = bcnt_q + CW'(1);
                csum_d = csum_nx;
                for (int unsigned k = 0; k < NCMD; k++) begin
                    if (bcnt_q == CW'(k + 2)) shadow_d[k] = fifoc_rxd;
                end
            end
            S_CHK: begin
                if (csum_match) begin
                    cmd_bus_d   = shadow_q;
                    cmd_valid_d = 1'b1;
                end else begin
                    err_code_d  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q       <= '0;
            bcnt_q      <= '0;
            rdcnt_q     <= '0;
            rxen_q      <= 1'b0;
            csum_q      <= '0;
            shadow_q    <= '0;
            cmd_bus_q   <= '0;
            cmd_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            lat_q       <= lat_d;
            bcnt_q      <= bcnt_d;
            rdcnt_q     <= rdcnt_d;
            rxen_q      <= rxen_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            cmd_bus_q   <= cmd_bus_d;
            cmd_valid_q <= cmd_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign fifoc_rxen = rxen_q;
    assign cmd_bus    = cmd_bus_q;
    assign cmd_valid  = cmd_valid_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_fifoc_cmd_frame_rx.sv
// Scoreboard bench for fifoc_cmd_frame_rx: three configurations (NCMD/RD_LAT = 9/2, 4/1, 4/4) each fed
// directed and random frames from a latency-accurate FIFO model; a per-config monitor checks every frame end.
module tb_fifoc_cmd_frame_rx;

    localparam logic [7:0] H0 = 8'h55;
    localparam logic [7:0] H1 = 8'hAA;

    typedef struct {
        bit          good;
        logic [1:0]  code;
        logic [71:0] bus;
        int          rxlen;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int g, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [cfg%0d]: got %h, expected %h", nm, g, act, exp);
        end
    endfunction

    function automatic logic [7:0] ref_csum(input logic [7:0] b [9], input int n);
        logic [7:0] s;
        s = 8'h00;
`ifdef FIFOC_CMD_XOR_CHK_EN
        for (int k = 0; k < n; k++) s = s ^ b[k];
`else
        for (int k = 0; k < n; k++) s = s + b[k];
`endif
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N  = (g == 0) ? 9 : 4;
        localparam int L  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int FL = N + 3;

        logic             rst;
        logic             fs;
        logic             fd;
        logic             err;
        logic [1:0]       err_code;
        logic             fifoc_rxen;
        logic [7:0]       fifoc_rxd;
        logic [8*N-1:0]   cmd_bus;
        logic             cmd_valid;
        logic [3:0]       check_show;
        bit               fin = 1'b0;

        logic [7:0]       fifo [$];
        logic [7:0]       pipe [L];
        exp_t             expq [$];

        fifoc_cmd_frame_rx #(
            .NCMD   (N),
            .RD_LAT (L),
            .HDR0   (H0),
            .HDR1   (H1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .fs         (fs),
            .fd         (fd),
            .err        (err),
            .err_code   (err_code),
            .fifoc_rxen (fifoc_rxen),
            .fifoc_rxd  (fifoc_rxd),
            .cmd_bus    (cmd_bus),
            .cmd_valid  (cmd_valid),
            .check_show (check_show)
        );

        // FIFO: a read enabled in cycle c presents its byte on rxd in cycle c+L; idle slots carry noise
        assign fifoc_rxd = pipe[L-1];
        always @(posedge clk) begin
            logic [7:0] b;
            if (fifoc_rxen && fifo.size() > 0) b = fifo.pop_front();
            else                               b = 8'($urandom);
            for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= b;
        end

        int vcnt = 0;
        int rxcnt = 0;
        bit prev_end = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                vcnt = 0;
                rxcnt = 0;
                prev_end = 1'b0;
            end else begin
                if (fifoc_rxen) rxcnt++;
                if (cmd_valid)  vcnt++;
                if ((fd || err) && !prev_end) begin
                    if (expq.size() == 0) begin
                        chk("spurious_end", g, 72'({fd, err}), 72'(0));
                    end else begin
                        e = expq.pop_front();
                        chk("end_kind",  g, 72'({fd, err}), 72'({e.good, !e.good}));
                        chk("err_code",  g, 72'(err_code), 72'(e.code));
                        chk("cmd_bus",   g, 72'(cmd_bus), e.bus);
                        chk("cmd_valid_pulses", g, 72'(vcnt), 72'(e.good ? 1 : 0));
                        chk("rxen_len",  g, 72'(rxcnt), 72'(e.rxlen));
                    end
                    vcnt = 0;
                    rxcnt = 0;
                end
                prev_end = fd || err;
            end
        end

        initial begin
            logic [7:0]  cmd [9];
            logic [7:0]  h0, h1, cs;
            logic [71:0] model_bus;
            int          kind, j, cyc, r;
            bit          early, good;
            exp_t        e;

            model_bus = '0;
            rst = 1'b1;
            fs  = 1'b0;
            repeat (3) @(negedge clk);
            chk("reset_ctl", g, 72'({fd, err, fifoc_rxen, cmd_valid, err_code}), 72'(0));
            chk("reset_bus", g, 72'(cmd_bus), 72'(0));
            rst = 1'b0;
            @(negedge clk);

            for (int f = 0; f < 30; f++) begin
                h0 = H0;
                h1 = H1;
                early = 1'b0;
                kind = 0;
                j = 0;
                for (int k = 0; k < 9; k++) cmd[k] = 8'($urandom);
                if (f == 0 || f == 3 || f == 5)
                    for (int k = 0; k < 9; k++) cmd[k] = (g == 0) ? 8'(k + 1) : 8'((k + 1) << 4);

                if (f == 1) begin
                    kind = 1;
                    j = 1;
                    h1 = 8'hAB;
                end else if (f == 3) begin
                    kind = 2;
                end else if (f == 4 && g == 0) begin
                    kind = 3;
                end else if (f > 5) begin
                    r = int'($urandom_range(0, 9));
                    kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
                    early = ($urandom_range(0, 3) == 0);
                    if (kind == 1) begin
                        j = int'($urandom_range(0, 1));
                        if (j == 0) h0 = H0 ^ 8'($urandom_range(1, 255));
                        else        h1 = H1 ^ 8'($urandom_range(1, 255));
                    end
                end

                cs = ref_csum(cmd, N);
                if (kind == 2) cs = (f == 3) ? cs - 8'd1 : cs ^ 8'($urandom_range(1, 255));

                fifo.push_back(h0);
                fifo.push_back(h1);
                for (int k = 0; k < N; k++) fifo.push_back(cmd[k]);
                fifo.push_back(cs);

                good = (kind == 0);
                if (kind != 3) begin
                    e.good  = good;
                    e.code  = (kind == 1) ? 2'b01 : ((kind == 2) ? 2'b10 : 2'b00);
                    e.rxlen = (kind == 1) ? (((j + L + 1) < FL) ? (j + L + 1) : FL) : FL;
                    if (good) begin
                        model_bus = '0;
                        for (int k = 0; k < N; k++) model_bus[8*k +: 8] = cmd[k];
                    end
                    e.bus = model_bus;
                    expq.push_back(e);
                end

                fs = 1'b1;

                if (kind == 3) begin
                    repeat (L + 7) @(negedge clk);
                    chk("pre_rst_busy", g, 72'(fifoc_rxen), 72'(1));
                    #1 rst = 1'b1;
                    #1;
                    chk("midframe_rst_ctl", g, 72'({fd, err, fifoc_rxen, cmd_valid, err_code}), 72'(0));
                    chk("midframe_rst_bus", g, 72'(cmd_bus), 72'(0));
                    model_bus = '0;
                    fs = 1'b0;
                    fifo.delete();
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                end else begin
                    cyc = 0;
                    while (!(fd || err) && cyc < 200) begin
                        @(negedge clk);
                        cyc++;
                        if (early && cyc == 2) fs = 1'b0;
                    end
                    chk("frame_end_seen", g, 72'(fd || err), 72'(1));
                    if (err) fifo.delete();
                    if (fs) begin
                        repeat ($urandom_range(0, 4)) @(negedge clk);
                        chk("hold_no_restart", g, 72'({fd, err, fifoc_rxen}), 72'({good, !good, 1'b0}));
                        fs = 1'b0;
                    end
                    @(negedge clk);
                    chk("back_to_idle", g, 72'({fd, err}), 72'(0));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 40000 && !(cfg[0].fin && cfg[1].fin && cfg[2].fin); c++) @(negedge clk);
        chk("all_configs_done", 0, 72'({cfg[0].fin, cfg[1].fin, cfg[2].fin}), 72'(3'b111));
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
